decode_stage: RTL and testbench



---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master: upstream fetch and downstream execute (drives in_*, out_ready).
// slave : decode stage (drives in_ready and the out_* payload).
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_alu_op;
    logic [2:0]      out_funct3;
    logic [10:0]     out_ctrl;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_alu_op, out_funct3, out_ctrl
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_alu_op, out_funct3, out_ctrl
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode into a 2-entry FIFO whose
// head register drives every output.
// Ports: clk, rst_n (async, active-low), flush (drop all entries),
//        bus (decode_stage_if.slave: in_* from fetch, out_* to execute),
//        illegal_cnt (saturating count of accepted illegal instructions).
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter bit          EN_M  = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_ALU_SRC   = 1;
    localparam int unsigned CTRL_BRANCH    = 2;
    localparam int unsigned CTRL_JAL       = 3;
    localparam int unsigned CTRL_JALR      = 4;
    localparam int unsigned CTRL_LOAD      = 5;
    localparam int unsigned CTRL_STORE     = 6;
    localparam int unsigned CTRL_LUI       = 7;
    localparam int unsigned CTRL_AUIPC     = 8;
    localparam int unsigned CTRL_DIV       = 9;
    localparam int unsigned CTRL_ILLEGAL   = 10;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_MUL = 5'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic [2:0]      funct3;
        logic [10:0]     ctrl;
    } entry_t;

    // funct3 -> ALU op; alt selects SUB/SRA
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = 5'd2;
            3'b010:  op = 5'd3;
            3'b011:  op = 5'd4;
            3'b100:  op = 5'd5;
            3'b101:  op = alt ? 5'd7 : 5'd6;
            3'b110:  op = 5'd8;
            default: op = 5'd9;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       writes;
    logic       illegal;
    entry_t     dec;

    // Combinational decode of the incoming word
    always_comb begin
        opcode  = bus.in_instr[6:0];
        f3      = bus.in_instr[14:12];
        f7      = bus.in_instr[31:25];
        writes  = 1'b0;
        illegal = 1'b0;
        dec     = '0;
        dec.pc  = bus.in_pc;
        case (opcode)
            7'b0110111: begin // LUI
                writes = 1'b1;
                dec.ctrl[CTRL_ALU_SRC] = 1'b1;
                dec.ctrl[CTRL_LUI]     = 1'b1;
                dec.imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
            end
            7'b0010111: begin // AUIPC
                writes = 1'b1;
                dec.ctrl[CTRL_ALU_SRC] = 1'b1;
                dec.ctrl[CTRL_AUIPC]   = 1'b1;
                dec.imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
            end
            7'b1101111: begin // JAL
                writes = 1'b1;
                dec.ctrl[CTRL_JAL] = 1'b1;
                dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                         bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
            end
            7'b1100111: begin // JALR
                illegal = (f3 != 3'b000);
                writes  = 1'b1;
                dec.ctrl[CTRL_JALR] = 1'b1;
                dec.rs1 = bus.in_instr[19:15];
                dec.imm = XLEN'($signed(bus.in_instr[31:20]));
            end
            7'b1100011: begin // BRANCH
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
                dec.ctrl[CTRL_BRANCH] = 1'b1;
                dec.rs1    = bus.in_instr[19:15];
                dec.rs2    = bus.in_instr[24:20];
                dec.funct3 = f3;
                dec.alu_op = ALU_SUB;
                dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                         bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
            end
            7'b0000011: begin // LOAD
                illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                writes  = 1'b1;
                dec.ctrl[CTRL_ALU_SRC] = 1'b1;
                dec.ctrl[CTRL_LOAD]    = 1'b1;
                dec.rs1    = bus.in_instr[19:15];
                dec.funct3 = f3;
                dec.imm    = XLEN'($signed(bus.in_instr[31:20]));
            end
            7'b0100011: begin // STORE
                illegal = (f3 > 3'b010);
                dec.ctrl[CTRL_ALU_SRC] = 1'b1;
                dec.ctrl[CTRL_STORE]   = 1'b1;
                dec.rs1    = bus.in_instr[19:15];
                dec.rs2    = bus.in_instr[24:20];
                dec.funct3 = f3;
                dec.imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
            end
            7'b0010011: begin // OP-IMM; shift-amount encodings are checked on imm[11:5]
                writes = 1'b1;
                dec.ctrl[CTRL_ALU_SRC] = 1'b1;
                dec.rs1    = bus.in_instr[19:15];
                dec.imm    = XLEN'($signed(bus.in_instr[31:20]));
                dec.alu_op = base_alu(f3, 1'b0);
                if (f3 == 3'b001) begin
                    illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    illegal    = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    dec.alu_op = base_alu(f3, f7[5]);
                end
            end
            7'b0110011: begin // OP
                writes  = 1'b1;
                dec.rs1 = bus.in_instr[19:15];
                dec.rs2 = bus.in_instr[24:20];
                if (f7 == 7'b0000000) begin
                    dec.alu_op = base_alu(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.alu_op = base_alu(f3, 1'b1);
                end else if (f7 == 7'b0000001 && EN_M) begin
                    if (f3[2]) begin
                        dec.ctrl[CTRL_DIV] = 1'b1;
                        dec.funct3 = f3;
                        dec.alu_op = ALU_ADD;
                    end else begin
                        dec.alu_op = ALU_MUL + 5'(f3[1:0]);
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0001111: begin // MISC-MEM: FENCE retires as a NOP
            end
            default: illegal = 1'b1;
        endcase

        // rd only meaningful when the instruction really writes a register
        if (writes && bus.in_instr[11:7] != 5'd0) begin
            dec.rd = bus.in_instr[11:7];
            dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        end
        if (illegal) begin
            dec = '0;
            dec.pc = bus.in_pc;
            dec.ctrl[CTRL_ILLEGAL] = 1'b1;
        end
    end

    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // FIFO next state; head register is zeroed whenever the FIFO empties
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        push    = bus.in_valid && ready_q && !flush;
        pop     = valid_q && bus.out_ready;
        if (flush) begin
            count_d = 2'd0;
            head_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = dec;
                    else                 tail_d = dec;
                    count_d = 2'(count_q + 2'd1);
                end
                2'b01: begin
                    head_d  = (count_q == 2'd2) ? tail_q : '0;
                    count_d = 2'(count_q - 2'd1);
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = dec;
                    end else begin
                        head_d = dec;
                    end
                end
                default: ;
            endcase
            if (push && dec.ctrl[CTRL_ILLEGAL] && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        valid_d = (count_d != 2'd0);
        ready_d = (count_d < 2'd2);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_pc     = head_q.pc;
    assign bus.out_rd     = head_q.rd;
    assign bus.out_rs1    = head_q.rs1;
    assign bus.out_rs2    = head_q.rs2;
    assign bus.out_imm    = head_q.imm;
    assign bus.out_alu_op = head_q.alu_op;
    assign bus.out_funct3 = head_q.funct3;
    assign bus.out_ctrl   = head_q.ctrl;
    assign illegal_cnt    = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (XLEN=32/EN_M=1/CNT_W=16 and
// XLEN=64/EN_M=0/CNT_W=3) share one stimulus stream and are compared every
// cycle against a queue-based reference model of the decode rules.
module tb_decode_stage;
    logic        clk;
    logic        rst_n;
    logic        drv_flush;
    logic        drv_valid;
    logic [31:0] drv_instr;
    logic [63:0] drv_pc;
    logic        drv_ordy;
    logic [15:0] cnt_a_o;
    logic [2:0]  cnt_b_o;

    int compared   = 0;
    int mismatched = 0;

    decode_stage_if #(.XLEN(32)) bus_a ();
    decode_stage_if #(.XLEN(64)) bus_b ();

    assign bus_a.in_valid  = drv_valid;
    assign bus_a.in_instr  = drv_instr;
    assign bus_a.in_pc     = drv_pc[31:0];
    assign bus_a.out_ready = drv_ordy;
    assign bus_b.in_valid  = drv_valid;
    assign bus_b.in_instr  = drv_instr;
    assign bus_b.in_pc     = drv_pc;
    assign bus_b.out_ready = drv_ordy;

    decode_stage #(.XLEN(32), .EN_M(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(drv_flush), .bus(bus_a.slave), .illegal_cnt(cnt_a_o));
    decode_stage #(.XLEN(64), .EN_M(1'b0), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(drv_flush), .bus(bus_b.slave), .illegal_cnt(cnt_b_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  alu;
        logic [2:0]  f3;
        logic [10:0] ctrl;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   cnt_a = 0;
    int   cnt_b = 0;

    // Reference decode: classify by opcode, pick fields by instruction format
    function automatic exp_t model_decode(input logic [31:0] w, input logic [63:0] pc, input bit en_m);
        exp_t e;
        logic [4:0] base [8];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        bit ok, wr;
        base  = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        op    = w[6:0];
        f3    = w[14:12];
        f7    = w[31:25];
        imm_i = {{52{w[31]}}, w[31:20]};
        imm_s = {{52{w[31]}}, w[31:25], w[11:7]};
        imm_b = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        imm_u = {{32{w[31]}}, w[31:12], 12'h000};
        imm_j = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e = '0;
        e.pc = pc;
        ok = 1'b1;
        wr = 1'b0;
        if (op == 7'h37) begin
            wr = 1; e.ctrl[1] = 1; e.ctrl[7] = 1; e.imm = imm_u;
        end else if (op == 7'h17) begin
            wr = 1; e.ctrl[1] = 1; e.ctrl[8] = 1; e.imm = imm_u;
        end else if (op == 7'h6F) begin
            wr = 1; e.ctrl[3] = 1; e.imm = imm_j;
        end else if (op == 7'h67) begin
            ok = (f3 == 0); wr = 1; e.ctrl[4] = 1; e.rs1 = w[19:15]; e.imm = imm_i;
        end else if (op == 7'h63) begin
            ok = !(f3 == 2 || f3 == 3);
            e.ctrl[2] = 1; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.imm = imm_b; e.f3 = f3; e.alu = 5'd1;
        end else if (op == 7'h03) begin
            ok = !(f3 == 3 || f3 == 6 || f3 == 7);
            wr = 1; e.ctrl[1] = 1; e.ctrl[5] = 1; e.rs1 = w[19:15]; e.imm = imm_i; e.f3 = f3;
        end else if (op == 7'h23) begin
            ok = (f3 <= 2);
            e.ctrl[1] = 1; e.ctrl[6] = 1; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.imm = imm_s; e.f3 = f3;
        end else if (op == 7'h13) begin
            wr = 1; e.ctrl[1] = 1; e.rs1 = w[19:15]; e.imm = imm_i; e.alu = base[f3];
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) begin
                ok = (f7 == 0) || (f7 == 7'h20);
                if (f7 == 7'h20) e.alu = 5'd7;
            end
        end else if (op == 7'h33) begin
            wr = 1; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            if (f7 == 0) e.alu = base[f3];
            else if (f7 == 7'h20 && f3 == 0) e.alu = 5'd1;
            else if (f7 == 7'h20 && f3 == 5) e.alu = 5'd7;
            else if (f7 == 7'h01 && en_m) begin
                if (f3 >= 4) begin e.ctrl[9] = 1; e.f3 = f3; e.alu = 5'd0; end
                else e.alu = 5'(10 + f3);
            end else ok = 1'b0;
        end else if (op == 7'h0F) begin
            // FENCE: no side effects
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e = '0; e.pc = pc; e.ctrl = 11'h400;
        end else if (wr && w[11:7] != 0) begin
            e.rd = w[11:7]; e.ctrl[0] = 1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = '0;
        eb = '0;
        if (q.size() > 0) begin
            ea = model_decode(q[0].w, q[0].pc, 1'b1);
            eb = model_decode(q[0].w, q[0].pc, 1'b0);
            ea.pc  = 64'(ea.pc[31:0]);
            ea.imm = 64'(ea.imm[31:0]);
        end
        chk("a_valid", 64'(bus_a.out_valid), 64'(q.size() > 0));
        chk("a_ready", 64'(bus_a.in_ready), 64'(q.size() < 2));
        chk("a_pc", 64'(bus_a.out_pc), ea.pc);
        chk("a_rd", 64'(bus_a.out_rd), 64'(ea.rd));
        chk("a_rs1", 64'(bus_a.out_rs1), 64'(ea.rs1));
        chk("a_rs2", 64'(bus_a.out_rs2), 64'(ea.rs2));
        chk("a_imm", 64'(bus_a.out_imm), ea.imm);
        chk("a_alu", 64'(bus_a.out_alu_op), 64'(ea.alu));
        chk("a_f3", 64'(bus_a.out_funct3), 64'(ea.f3));
        chk("a_ctrl", 64'(bus_a.out_ctrl), 64'(ea.ctrl));
        chk("a_cnt", 64'(cnt_a_o), 64'(cnt_a));
        chk("b_valid", 64'(bus_b.out_valid), 64'(q.size() > 0));
        chk("b_ready", 64'(bus_b.in_ready), 64'(q.size() < 2));
        chk("b_pc", bus_b.out_pc, eb.pc);
        chk("b_rd", 64'(bus_b.out_rd), 64'(eb.rd));
        chk("b_rs1", 64'(bus_b.out_rs1), 64'(eb.rs1));
        chk("b_rs2", 64'(bus_b.out_rs2), 64'(eb.rs2));
        chk("b_imm", bus_b.out_imm, eb.imm);
        chk("b_alu", 64'(bus_b.out_alu_op), 64'(eb.alu));
        chk("b_f3", 64'(bus_b.out_funct3), 64'(eb.f3));
        chk("b_ctrl", 64'(bus_b.out_ctrl), 64'(eb.ctrl));
        chk("b_cnt", 64'(cnt_b_o), 64'(cnt_b));
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [63:0] pc,
                         input bit ordy, input bit fl);
        @(negedge clk);
        drv_valid = v;
        drv_instr = w;
        drv_pc    = pc;
        drv_ordy  = ordy;
        drv_flush = fl;
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare
    task automatic step();
        bit   can_push;
        exp_t e1, e0;
        ent_t n;
        @(posedge clk);
        if (drv_flush) begin
            q.delete();
        end else begin
            can_push = (q.size() < 2);
            if (drv_ordy && q.size() > 0) void'(q.pop_front());
            if (drv_valid && can_push) begin
                n.w  = drv_instr;
                n.pc = drv_pc;
                q.push_back(n);
                e1 = model_decode(drv_instr, drv_pc, 1'b1);
                e0 = model_decode(drv_instr, drv_pc, 1'b0);
                if (e1.ctrl[10] && cnt_a < 65535) cnt_a++;
                if (e0.ctrl[10] && cnt_b < 7) cnt_b++;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 9)];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        int saved_cnt;
        rst_n     = 1'b0;
        drv_flush = 1'b0;
        drv_valid = 1'b0;
        drv_instr = '0;
        drv_pc    = '0;
        drv_ordy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADDI x5,x0,-1 with one-cycle latency
        drive(1, 32'hFFF00293, 64'h100, 1, 0); step();
        chk("addi_valid", 64'(bus_a.out_valid), 64'd1);
        chk("addi_rd", 64'(bus_a.out_rd), 64'd5);
        chk("addi_imm", 64'(bus_a.out_imm), 64'hFFFF_FFFF);
        chk("addi_ctrl", 64'(bus_a.out_ctrl), 64'h003);
        drive(0, 0, 0, 1, 0); step();

        // Backpressure: three offered, two accepted, drained in order
        drive(1, 32'h00100093, 64'h200, 0, 0); step();
        drive(1, 32'h00200113, 64'h204, 0, 0); step();
        chk("full_ready", 64'(bus_a.in_ready), 64'd0);
        drive(1, 32'h00300193, 64'h208, 0, 0); step();
        chk("full_head_pc", 64'(bus_a.out_pc), 64'h200);
        drive(0, 0, 0, 1, 0); step();
        chk("drain_pc1", 64'(bus_a.out_pc), 64'h204);
        step();
        chk("drain_empty", 64'(bus_a.out_valid), 64'd0);

        // Zero word and DIV with M disabled are both illegal
        drive(1, 32'h00000000, 64'h300, 1, 0); step();
        chk("ill0_ctrl", 64'(bus_b.out_ctrl), 64'h400);
        drive(1, 32'h0200C033, 64'h304, 1, 0); step();
        chk("div_noM_ctrl", 64'(bus_b.out_ctrl), 64'h400);
        chk("div_noM_cnt", 64'(cnt_b_o), 64'd2);
        chk("div_M_ctrl", 64'(bus_a.out_ctrl), 64'h200);

        // JAL x0,+8 and SW
        drive(1, 32'h0080006F, 64'h400, 1, 0); step();
        chk("jal_ctrl", 64'(bus_a.out_ctrl), 64'h008);
        chk("jal_rd", 64'(bus_a.out_rd), 64'd0);
        chk("jal_imm", 64'(bus_a.out_imm), 64'd8);
        drive(1, 32'h00112223, 64'h404, 1, 0); step();
        chk("sw_ctrl", 64'(bus_a.out_ctrl), 64'h042);
        chk("sw_f3", 64'(bus_a.out_funct3), 64'd2);
        chk("sw_imm", 64'(bus_a.out_imm), 64'd4);

        // Flush on a full FIFO beats push and pop
        drive(1, 32'h00000000, 64'h500, 0, 0); step();
        drive(1, 32'h00000000, 64'h504, 0, 0); step();
        saved_cnt = cnt_b;
        drive(1, 32'h00000000, 64'h508, 1, 1); step();
        chk("flush_valid", 64'(bus_b.out_valid), 64'd0);
        chk("flush_cnt", 64'(cnt_b_o), 64'(saved_cnt));
        drive(0, 0, 0, 0, 0); step();

        // Asynchronous reset with two entries buffered
        drive(1, 32'h00000000, 64'h600, 0, 0); step();
        drive(1, 32'h00000000, 64'h604, 0, 0); step();
        @(negedge clk);
        rst_n = 1'b0;
        drv_valid = 1'b0;
        #1;
        chk("arst_a_valid", 64'(bus_a.out_valid), 64'd0);
        chk("arst_b_valid", 64'(bus_b.out_valid), 64'd0);
        chk("arst_a_cnt", 64'(cnt_a_o), 64'd0);
        chk("arst_b_cnt", 64'(cnt_b_o), 64'd0);
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Counter saturation on the narrow instance
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h00000000, 64'(32'h700 + 4 * i), 1, 0); step();
        end
        chk("sat_b_cnt", 64'(cnt_b_o), 64'd7);
        chk("sat_a_cnt", 64'(cnt_a_o), 64'd10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
